// File: rtl/div_unit_if.sv
// Request/response bundle for div_unit: one RV32M divide request in, one 32-bit result out.
interface div_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  func3;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] result;

   modport master (
      output req_valid, func3, rs1, rs2, rsp_ready,
      input  req_ready, rsp_valid, result
   );

   modport slave (
      input  req_valid, func3, rs1, rs2, rsp_ready,
      output req_ready, rsp_valid, result
   );
endinterface

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: 32-step radix-2 restoring divider with fast paths.
// Optional macro DIV_RESULT_CACHE_EN keeps the last normal result for single-edge replays.
module div_unit (
   input  logic       clk,
   input  logic       clr_n,
   input  logic       flush,
   output logic       busy,
   div_unit_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] result_q, result_d;
   logic        is_rem_q, is_rem_d;
   logic        q_neg_q, q_neg_d;
   logic        r_neg_q, r_neg_d;
   logic        rdy_en_q;

   logic        in_signed, in_rem, in_legal, in_ovf, accept;
   logic [31:0] mag1, mag2, q_fix, r_fix;
   logic [32:0] step_shift, step_diff;

   assign in_signed = ~bus.func3[0];
   assign in_rem    = bus.func3[1];
   assign in_legal  = bus.func3[2];
   assign in_ovf    = in_signed && (bus.rs1 == 32'h8000_0000) && (bus.rs2 == 32'hFFFF_FFFF);
   assign mag1      = (in_signed && bus.rs1[31]) ? 32'd0 - bus.rs1 : bus.rs1;
   assign mag2      = (in_signed && bus.rs2[31]) ? 32'd0 - bus.rs2 : bus.rs2;

   // Shifted partial remainder is 33 bits wide; its borrow decides the quotient bit.
   assign step_shift = {rem_q, quo_q[31]};
   assign step_diff  = step_shift - {1'b0, dvs_q};
   assign q_fix      = q_neg_q ? 32'd0 - quo_q : quo_q;
   assign r_fix      = r_neg_q ? 32'd0 - rem_q : rem_q;

   assign bus.req_ready = rdy_en_q && (state_q == StIdle) && !flush;
   assign bus.rsp_valid = (state_q == StDone);
   assign bus.result    = result_q;
   assign busy          = (state_q != StIdle);
   assign accept        = bus.req_valid && bus.req_ready;

`ifdef DIV_RESULT_CACHE_EN
   logic        c_valid_q, c_valid_d, c_signed_q, c_signed_d, op_signed_q, op_signed_d;
   logic [31:0] c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d, c_quo_q, c_quo_d, c_rem_q, c_rem_d;
   logic [31:0] op_rs1_q, op_rs1_d, op_rs2_q, op_rs2_d;
   logic        cache_hit;

   assign cache_hit = c_valid_q && (bus.rs1 == c_rs1_q) && (bus.rs2 == c_rs2_q) &&
                      (in_signed == c_signed_q);

   always_comb begin
      c_valid_d   = c_valid_q;
      c_signed_d  = c_signed_q;
      c_rs1_d     = c_rs1_q;
      c_rs2_d     = c_rs2_q;
      c_quo_d     = c_quo_q;
      c_rem_d     = c_rem_q;
      op_signed_d = op_signed_q;
      op_rs1_d    = op_rs1_q;
      op_rs2_d    = op_rs2_q;
      if (accept) begin
         op_signed_d = in_signed;
         op_rs1_d    = bus.rs1;
         op_rs2_d    = bus.rs2;
      end
      if (state_q == StFix) begin
         c_valid_d  = 1'b1;
         c_signed_d = op_signed_q;
         c_rs1_d    = op_rs1_q;
         c_rs2_d    = op_rs2_q;
         c_quo_d    = q_fix;
         c_rem_d    = r_fix;
      end
      if (flush) c_valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         c_valid_q   <= 1'b0;
         c_signed_q  <= 1'b0;
         c_rs1_q     <= '0;
         c_rs2_q     <= '0;
         c_quo_q     <= '0;
         c_rem_q     <= '0;
         op_signed_q <= 1'b0;
         op_rs1_q    <= '0;
         op_rs2_q    <= '0;
      end else begin
         c_valid_q   <= c_valid_d;
         c_signed_q  <= c_signed_d;
         c_rs1_q     <= c_rs1_d;
         c_rs2_q     <= c_rs2_d;
         c_quo_q     <= c_quo_d;
         c_rem_q     <= c_rem_d;
         op_signed_q <= op_signed_d;
         op_rs1_q    <= op_rs1_d;
         op_rs2_q    <= op_rs2_d;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      result_d = result_q;
      is_rem_d = is_rem_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               is_rem_d = in_rem;
               if (!in_legal) begin
                  result_d = '0;
                  state_d  = StDone;
               end else if (bus.rs2 == 32'd0) begin
                  result_d = in_rem ? bus.rs1 : 32'hFFFF_FFFF;
                  state_d  = StDone;
               end else if (in_ovf) begin
                  result_d = in_rem ? 32'd0 : 32'h8000_0000;
                  state_d  = StDone;
`ifdef DIV_RESULT_CACHE_EN
               end else if (cache_hit) begin
                  result_d = in_rem ? c_rem_q : c_quo_q;
                  state_d  = StDone;
`endif
               end else begin
                  rem_d   = '0;
                  quo_d   = mag1;
                  dvs_d   = mag2;
                  q_neg_d = in_signed && (bus.rs1[31] ^ bus.rs2[31]);
                  r_neg_d = in_signed && bus.rs1[31];
                  cnt_d   = '0;
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            if (!step_diff[32]) begin
               rem_d = step_diff[31:0];
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = step_shift[31:0];
               quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = StFix;
         end
         StFix: begin
            result_d = is_rem_q ? r_fix : q_fix;
            state_d  = StDone;
         end
         StDone: begin
            if (bus.rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (flush) begin
         state_d = StIdle;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         result_q <= '0;
         is_rem_q <= 1'b0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         result_q <= result_d;
         is_rem_q <= is_rem_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         rdy_en_q <= 1'b1;
      end
   end

endmodule
